// File: rtl/mcr_dial_encoder.sv
`default_nettype none
// ============================================================================
// Module      : mcr_dial_encoder
// Description : Produces the absolute dial angle for the MCR1 Kick input.
//               Two motion sources drive one shared position accumulator.
//               The first source is digital left/right motion, paced by the
//               rising edges of vsync and sped up when the button is held.
//               The second source is the relative spinner word from hps_io.
// Ports       : i_clk       system clock (clk_sys)
//               i_reset     synchronous, active-high reset
//               i_fast      force the fast digital step
//               i_minus     digital counter-clockwise
//               i_plus      digital clockwise
//               i_strobe    frame pacing level (vsync); rising edge = tick
//               i_spin_in   [8] toggles per sample, [7:0] signed delta
//               o_spin_out  integer part of the accumulator
// Revision    : 1.0 - initial release
// ============================================================================
module mcr_dial_encoder #(
    parameter int ANGLE_W      = 4,
    parameter int FRAC_W       = 4,
    parameter int DIG_STEP     = 8,
    parameter int FAST_SHIFT   = 1,
    parameter int ACCEL_FRAMES = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_fast,
    input  logic               i_minus,
    input  logic               i_plus,
    input  logic               i_strobe,
    input  logic [8:0]         i_spin_in,
    output logic [ANGLE_W-1:0] o_spin_out
);

    localparam int c_pos_w = ANGLE_W + FRAC_W;
    localparam int c_cnt_w = $clog2(ACCEL_FRAMES + 1);

    localparam logic [c_cnt_w-1:0] c_accel_cnt  = c_cnt_w'(ACCEL_FRAMES);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
    localparam logic [c_pos_w:0]   c_dstep_slow = (c_pos_w + 1)'(DIG_STEP);
    localparam logic [c_pos_w:0]   c_dstep_fast = (c_pos_w + 1)'(DIG_STEP << FAST_SHIFT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SLOW  = 2'd1,
        S_ACCEL = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_pos_w-1:0]   r_pos;
    logic [c_cnt_w-1:0]   r_hold_cnt;
    logic                 r_dir_plus;     // direction latched on the current run
    logic                 r_strobe_d;
    logic                 r_tog_d;

    logic                 w_stb_ev;
    logic                 w_spn_ev;
    logic                 w_dir;
    logic                 w_reversed;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic [c_pos_w:0]     w_dstep;
    logic [c_pos_w:0]     w_dig_delta;
    logic [c_pos_w:0]     w_ana_raw;
    logic [c_pos_w:0]     w_ana_delta;
    logic [c_pos_w:0]     w_sum;

    assign w_stb_ev   = i_strobe & ~r_strobe_d;
    assign w_spn_ev   = i_spin_in[8] ^ r_tog_d;
    assign w_dir      = i_plus ^ i_minus;
    assign w_reversed = (i_plus != r_dir_plus);

    // The counter stops at all-ones so that a long press never wraps back to slow.
    assign w_cnt_inc  = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + c_cnt_one;

    // The step size depends on the state before this tick's FSM update.
    // The fast input and the ACCEL state share a single shift, so they do not stack.
    assign w_dstep     = (i_fast || (r_state == S_ACCEL)) ? c_dstep_fast : c_dstep_slow;
    assign w_dig_delta = !(w_stb_ev && w_dir) ? '0 :
                         i_plus ? w_dstep : (~w_dstep + 1'b1);

    // Sign-extend the spinner delta to the accumulator width plus one bit.
    if (c_pos_w + 1 > 8) begin : g_astep_ext
        assign w_ana_raw = {{(c_pos_w + 1 - 8){i_spin_in[7]}}, i_spin_in[7:0]};
    end else if (c_pos_w + 1 == 8) begin : g_astep_eq
        assign w_ana_raw = i_spin_in[7:0];
    end else begin : g_astep_trunc
        assign w_ana_raw = i_spin_in[c_pos_w:0];
    end

    assign w_ana_delta = w_spn_ev ? w_ana_raw : '0;

    // Both sources are summed in one cycle. The carry-out is dropped so that
    // motion wraps modulo 2^POS_W in both directions.
    assign w_sum = {1'b0, r_pos} + w_dig_delta + w_ana_delta;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos      <= '0;
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_dir_plus <= 1'b0;
            // Load the edge detectors from the live inputs. A level that is
            // already present at reset release does not count as an event.
            r_strobe_d <= i_strobe;
            r_tog_d    <= i_spin_in[8];
        end else begin
            r_strobe_d <= i_strobe;
            r_tog_d    <= i_spin_in[8];
            r_pos      <= w_sum[c_pos_w-1:0];

            if (w_stb_ev) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_dir) begin
                            r_state    <= S_SLOW;
                            r_hold_cnt <= c_cnt_one;
                            r_dir_plus <= i_plus;
                        end
                    end
                    S_SLOW: begin
                        if (!w_dir) begin
                            r_state    <= S_IDLE;
                            r_hold_cnt <= '0;
                        end else if (w_reversed) begin
                            r_hold_cnt <= c_cnt_one;
                            r_dir_plus <= i_plus;
                        end else begin
                            r_hold_cnt <= w_cnt_inc;
                            if (w_cnt_inc >= c_accel_cnt) begin
                                r_state <= S_ACCEL;
                            end
                        end
                    end
                    S_ACCEL: begin
                        if (!w_dir) begin
                            r_state    <= S_IDLE;
                            r_hold_cnt <= '0;
                        end else if (w_reversed) begin
                            r_state    <= S_SLOW;
                            r_hold_cnt <= c_cnt_one;
                            r_dir_plus <= i_plus;
                        end else begin
                            r_hold_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_spin_out = r_pos[c_pos_w-1:FRAC_W];

endmodule
`default_nettype wire

// File: tb/tb_mcr_dial_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcr_dial_encoder
// Description : Self-checking bench for mcr_dial_encoder. It runs directed
//               scenarios and then randomized stimulus. Results are compared
//               against a reference model of the accumulator. The model is
//               based on run length and acts on each event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcr_dial_encoder;

    localparam int ANGLE_W      = 4;
    localparam int FRAC_W       = 4;
    localparam int DIG_STEP     = 8;
    localparam int FAST_SHIFT   = 1;
    localparam int ACCEL_FRAMES = 16;
    localparam int POS_MASK     = (1 << (ANGLE_W + FRAC_W)) - 1;

    logic               clk;
    logic               i_reset;
    logic               i_fast;
    logic               i_minus;
    logic               i_plus;
    logic               i_strobe;
    logic [8:0]         i_spin_in;
    logic [ANGLE_W-1:0] o_spin_out;

    int errors;
    int checks;

    // Reference model state. It counts consecutive same-direction ticks and
    // does not track the DUT's FSM encoding.
    int m_pos;
    int m_run;
    bit m_last_plus;
    bit m_sd;
    bit m_td;

    mcr_dial_encoder #(
        .ANGLE_W     (ANGLE_W),
        .FRAC_W      (FRAC_W),
        .DIG_STEP    (DIG_STEP),
        .FAST_SHIFT  (FAST_SHIFT),
        .ACCEL_FRAMES(ACCEL_FRAMES)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_fast    (i_fast),
        .i_minus   (i_minus),
        .i_plus    (i_plus),
        .i_strobe  (i_strobe),
        .i_spin_in (i_spin_in),
        .o_spin_out(o_spin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // Applies the current inputs to the model. It then advances one clock and
    // samples 1 ns after the edge.
    task automatic tick();
        int  delta;
        int  stepv;
        byte sd;
        if (i_reset) begin
            m_pos = 0;
            m_run = 0;
        end else begin
            delta = 0;
            if (i_strobe && !m_sd) begin
                if (i_plus != i_minus) begin
                    stepv = (i_fast || (m_run >= ACCEL_FRAMES)) ? (DIG_STEP << FAST_SHIFT) : DIG_STEP;
                    delta += i_plus ? stepv : -stepv;
                    if (m_run == 0 || i_plus != m_last_plus) m_run = 1;
                    else if (m_run < 1000) m_run++;
                    m_last_plus = i_plus;
                end else begin
                    m_run = 0;
                end
            end
            if (i_spin_in[8] != m_td) begin
                sd = i_spin_in[7:0];
                delta += int'(sd);
            end
            m_pos = (m_pos + delta) & POS_MASK;
        end
        m_sd = i_strobe;
        m_td = i_spin_in[8];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_plus = 1'b0; i_minus = 1'b0; i_fast = 1'b0; i_strobe = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
        tick();
    endtask

    task automatic rise();
        i_strobe = 1'b1;
        tick();
    endtask

    task automatic fall();
        i_strobe = 1'b0;
        tick();
    endtask

    task automatic spin(input logic [7:0] d);
        i_spin_in = {~i_spin_in[8], d};
        tick();
    endtask

    task automatic test_reset();
        i_spin_in = 9'h000;
        do_reset();
        checks++;
        if (o_spin_out !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: spin_out=%0d expected=0", o_spin_out);
        end
    endtask

    task automatic test_plus_steps();
        logic [3:0] exp_tab [2];
        exp_tab[0] = 4'd0;
        exp_tab[1] = 4'd1;
        do_reset();
        i_plus = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rise();
            checks++;
            if (o_spin_out !== exp_tab[k]) begin
                errors++;
                $display("FAIL plus_step edge%0d: spin_out=%0d expected=%0d", k + 1, o_spin_out, exp_tab[k]);
            end
            fall();
        end
        i_plus = 1'b0;
    endtask

    task automatic test_minus_wrap();
        do_reset();
        i_minus = 1'b1;
        rise();
        checks++;
        if (o_spin_out !== 4'd15) begin
            errors++;
            $display("FAIL minus_wrap: spin_out=%0d expected=15", o_spin_out);
        end
        fall();
        i_plus = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rise();
            fall();
            checks++;
            if (o_spin_out !== 4'd15) begin
                errors++;
                $display("FAIL both_pressed edge%0d: spin_out=%0d expected=15", k + 1, o_spin_out);
            end
        end
        i_plus = 1'b0; i_minus = 1'b0;
    endtask

    task automatic test_fast();
        logic [3:0] exp_v;
        do_reset();
        i_plus = 1'b1;
        i_fast = 1'b1;
        // Every edge adds 16. The fast step is still +16 after the run reaches ACCEL.
        for (int k = 1; k <= 23; k++) begin
            rise();
            exp_v = 4'(k);
            checks++;
            if (o_spin_out !== exp_v) begin
                errors++;
                $display("FAIL fast edge%0d: spin_out=%0d expected=%0d", k, o_spin_out, exp_v);
            end
            fall();
        end
        i_plus = 1'b0;
        i_fast = 1'b0;
    endtask

    task automatic test_accel();
        int         pos;
        logic [3:0] exp_v;
        do_reset();
        i_plus = 1'b1;
        pos = 0;
        for (int k = 1; k <= 20; k++) begin
            rise();
            pos += (k <= 16) ? 8 : 16;
            exp_v = 4'(pos >> 4);
            checks++;
            if (o_spin_out !== exp_v) begin
                errors++;
                $display("FAIL accel edge%0d: spin_out=%0d expected=%0d", k, o_spin_out, exp_v);
            end
            fall();
        end
        // Release for one edge. After the button is pressed again, the motion
        // restarts at the slow rate: 0xC0 -> 0xC8 -> 0xD0.
        i_plus = 1'b0;
        rise(); fall();
        i_plus = 1'b1;
        rise(); fall();
        rise(); fall();
        checks++;
        if (o_spin_out !== 4'd13) begin
            errors++;
            $display("FAIL accel_release: spin_out=%0d expected=13", o_spin_out);
        end
        i_plus = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_plus = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rise(); fall();
        end
        // Apply a strobe edge and a spinner toggle in the same cycle:
        // 0x20 + 8 + 5 = 0x2D. Then add 3 more, which gives 0x30.
        i_strobe  = 1'b1;
        i_spin_in = {~i_spin_in[8], 8'h05};
        tick();
        checks++;
        if (o_spin_out !== 4'd2) begin
            errors++;
            $display("FAIL combined: spin_out=%0d expected=2", o_spin_out);
        end
        i_plus = 1'b0;
        fall();
        spin(8'h03);
        checks++;
        if (o_spin_out !== 4'd3) begin
            errors++;
            $display("FAIL combined_sum: spin_out=%0d expected=3", o_spin_out);
        end
    endtask

    task automatic test_spin_reset();
        do_reset();
        spin(8'h80);
        checks++;
        if (o_spin_out !== 4'd8) begin
            errors++;
            $display("FAIL spin_neg128: spin_out=%0d expected=8", o_spin_out);
        end
        // Assert reset while the spinner toggles and strobe rises. Keep fast
        // and plus held so that a phantom event would become visible.
        i_reset   = 1'b1;
        i_strobe  = 1'b1;
        i_plus    = 1'b1;
        i_fast    = 1'b1;
        i_spin_in = {~i_spin_in[8], 8'h20};
        tick();
        checks++;
        if (o_spin_out !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: spin_out=%0d expected=0", o_spin_out);
        end
        i_reset = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (o_spin_out !== 4'd0) begin
            errors++;
            $display("FAIL no_phantom: spin_out=%0d expected=0", o_spin_out);
        end
        i_plus = 1'b0;
        i_fast = 1'b0;
        fall();
        spin(8'h10);
        checks++;
        if (o_spin_out !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_spin: spin_out=%0d expected=1", o_spin_out);
        end
    endtask

    task automatic test_random();
        logic [1:0] mode;
        logic [3:0] exp_v;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                mode    = 2'($urandom_range(0, 3));
                i_plus  = mode[0];
                i_minus = mode[1];
            end
            i_fast = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) i_strobe = ~i_strobe;
            if ($urandom_range(0, 5) == 0) i_spin_in = {~i_spin_in[8], 8'($urandom)};
            else                           i_spin_in[7:0] = 8'($urandom);
            i_reset = ($urandom_range(0, 199) == 0);
            tick();
            exp_v = 4'(m_pos >> FRAC_W);
            checks++;
            if (o_spin_out !== exp_v) begin
                errors++;
                $display("FAIL random cycle%0d: spin_out=%0d expected=%0d", n, o_spin_out, exp_v);
            end
        end
        i_reset = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_pos = 0; m_run = 0; m_last_plus = 1'b0; m_sd = 1'b0; m_td = 1'b0;
        i_reset = 1'b1; i_fast = 1'b0; i_minus = 1'b0; i_plus = 1'b0;
        i_strobe = 1'b0; i_spin_in = 9'h000;
        test_reset();
        test_plus_steps();
        test_minus_wrap();
        test_fast();
        test_accel();
        test_back_to_back();
        test_spin_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
